// File: rtl/instr_mem_loader_if.sv
// Host byte link, instruction memory write port and core control signals
// of the instruction memory loader, bundled as one interface.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  // Host / system side: launches loads, streams bytes, observes results
  modport master (
    output start, num_words, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, err
  );

  // Loader side
  modport slave (
    input  start, num_words, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit
// words, writes them to consecutive word addresses, verifies a trailing
// XOR checksum and releases the core from reset only on a clean load.
module instr_mem_loader #(
  parameter int ADDR_W = 8
) (
  input logic               clk,
  input logic               rst,
  instr_mem_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;

  // Largest legal word count (whole memory); counters carry one extra bit
  // so the final count never aliases onto address 0.
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W     = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   nwords;
  logic [23:0]       acc;
  logic [31:0]       csum;

  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              core_rst_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  logic              ready;
  logic              take;
  logic              accept;
  logic              start_ok;
  logic              last_byte;
  logic              last_word;
  logic [31:0]       word_in;

  assign ready     = (state == LOAD) || (state == CHECK);
  assign take      = bus.byte_valid && ready;
  assign accept    = bus.start && ((state == IDLE) || (state == DONE));
  assign start_ok  = (bus.num_words != '0) && (bus.num_words <= MAX_WORDS);
  assign last_byte = take && (byte_cnt == 2'd3);
  assign last_word = (word_cnt == (nwords - ONE_W));
  // Earlier bytes sit in the high lanes; the byte arriving now fills [7:0].
  assign word_in   = {acc, bus.byte_data};

  assign bus.byte_ready = ready;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.core_rst   = core_rst_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; start is only honoured when no load is running
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nx = start_ok ? LOAD : DONE;
      LOAD:       if (last_byte) state_nx = WRITE;
      WRITE:      state_nx = last_word ? CHECK : LOAD;
      CHECK:      if (last_byte) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Byte assembly, memory write port, checksum and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt    <= '0;
      word_cnt    <= '0;
      nwords      <= '0;
      acc         <= '0;
      csum        <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      core_rst_r  <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mem_we_r <= 1'b0;
      if (accept) begin
        if (start_ok) begin
          nwords     <= bus.num_words;
          word_cnt   <= '0;
          byte_cnt   <= '0;
          acc        <= '0;
          csum       <= '0;
          busy_r     <= 1'b1;
          core_rst_r <= 1'b1;
          done_r     <= 1'b0;
          err_r      <= 1'b0;
        end else begin
          // Rejected word count: report a failed load without touching memory
          busy_r     <= 1'b0;
          core_rst_r <= 1'b1;
          done_r     <= 1'b1;
          err_r      <= 1'b1;
        end
      end
      if (take) begin
        byte_cnt <= byte_cnt + 2'd1;
        acc      <= word_in[23:0];
      end
      if ((state == LOAD) && last_byte) begin
        mem_we_r    <= 1'b1;
        mem_addr_r  <= word_cnt[ADDR_W-1:0];
        mem_wdata_r <= word_in;
      end
      if (state == WRITE) begin
        csum     <= csum ^ mem_wdata_r;
        word_cnt <= word_cnt + ONE_W;
      end
      if ((state == CHECK) && last_byte) begin
        busy_r     <= 1'b0;
        done_r     <= 1'b1;
        err_r      <= (word_in != csum);
        core_rst_r <= (word_in != csum);
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader against a stream-level model:
// expected words, addresses and checksum verdict are derived from the byte
// list alone.
module tb_instr_mem_loader;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim[$];
  logic [31:0] exp_words[1 << ADDR_W];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Fill stim with n random words plus their XOR checksum, optionally spoiled
  task automatic fill_random(input int n, input bit corrupt);
    logic [31:0] x;
    logic [31:0] w;
    stim.delete();
    x = '0;
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      x ^= w;
      stim.push_back(w[31:24]); stim.push_back(w[23:16]);
      stim.push_back(w[15:8]);  stim.push_back(w[7:0]);
    end
    if (corrupt) x ^= (32'h1 << $urandom_range(31, 0));
    stim.push_back(x[31:24]); stim.push_back(x[23:16]);
    stim.push_back(x[15:8]);  stim.push_back(x[7:0]);
  endtask

  task automatic fill_bytes(input logic [31:0] words[], input logic [31:0] sum);
    stim.delete();
    foreach (words[k]) begin
      stim.push_back(words[k][31:24]); stim.push_back(words[k][23:16]);
      stim.push_back(words[k][15:8]);  stim.push_back(words[k][7:0]);
    end
    stim.push_back(sum[31:24]); stim.push_back(sum[23:16]);
    stim.push_back(sum[15:8]);  stim.push_back(sum[7:0]);
  endtask

  // pct<0 selects the fixed 1,0,0 valid pattern; mid_start pulses a stray start
  task automatic run_load(input int n, input int pct, input bit mid_start);
    int total, idx, wi, cyc;
    bit pend, exp_err;
    logic [31:0] xw, cs;
    total = 4 * n + 4;
    xw = '0;
    for (int k = 0; k < n; k++) begin
      exp_words[k] = (32'(stim[4*k]) << 24) | (32'(stim[4*k+1]) << 16) |
                     (32'(stim[4*k+2]) << 8) | 32'(stim[4*k+3]);
      xw ^= exp_words[k];
    end
    cs = (32'(stim[4*n]) << 24) | (32'(stim[4*n+1]) << 16) |
         (32'(stim[4*n+2]) << 8) | 32'(stim[4*n+3]);
    exp_err = (cs != xw);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_words = 9'(n); bus.byte_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_start", bus.busy, 1);
    chk("core_rst_load", bus.core_rst, 1);
    chk("done_clr", bus.done, 0);

    idx = 0; wi = 0; pend = 0; cyc = 0;
    while (idx < total && cyc < 20 * total + 50) begin
      @(posedge clk); #1;
      if (pct < 0) bus.byte_valid = (cyc % 3 == 0);
      else         bus.byte_valid = ($urandom_range(99, 0) < pct);
      bus.byte_data = stim[idx];
      if (mid_start && cyc == 7) begin
        bus.start = 1'b1; bus.num_words = 9'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      chk("we", bus.mem_we, pend);
      if (pend) chk("rdy_in_write", bus.byte_ready, 0);
      if (bus.mem_we) begin
        chk("addr", bus.mem_addr, wi);
        chk("wdata", bus.mem_wdata, exp_words[wi]);
        wi++;
      end
      pend = 0;
      if (bus.byte_valid && bus.byte_ready) begin
        if (idx < 4 * n && idx % 4 == 3) pend = 1;
        idx++;
      end
      cyc++;
    end
    chk("stream_consumed", idx, total);

    @(posedge clk); #1;
    bus.byte_valid = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("done", bus.done, 1);
    chk("err", bus.err, exp_err);
    chk("core_rst_end", bus.core_rst, exp_err);
    chk("busy_end", bus.busy, 0);
    chk("nwrites", wi, n);

    // Bytes offered after completion must be ignored and status must hold
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.byte_valid = 1'b1;
      @(negedge clk);
      chk("rdy_done", bus.byte_ready, 0);
      chk("we_done", bus.mem_we, 0);
      chk("done_hold", bus.done, 1);
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic bad_start(input int n);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_words = 9'(n); bus.byte_valid = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("bad_done", bus.done, 1);
    chk("bad_err", bus.err, 1);
    chk("bad_rdy", bus.byte_ready, 0);
    chk("bad_core_rst", bus.core_rst, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("bad_we", bus.mem_we, 0);
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic reset_mid_load();
    int idx, cyc;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_words = 9'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.byte_valid = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 100) begin
      bus.byte_data = stim[idx];
      @(negedge clk);
      if (bus.byte_valid && bus.byte_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.byte_valid = 1'b0;
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rdy", bus.byte_ready, 0);
    chk("arst_we", bus.mem_we, 0);
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_wdata", bus.mem_wdata, 0);
    chk("arst_core_rst", bus.core_rst, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_err", bus.err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w2[];
    logic [31:0] w1[];
    bus.start = 1'b0; bus.num_words = '0; bus.byte_valid = 1'b0; bus.byte_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", bus.byte_ready, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_core_rst", bus.core_rst, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);

    w2 = new[2];
    w2[0] = 32'h12345678; w2[1] = 32'h9ABCDEF0;
    fill_bytes(w2, 32'h88888888);
    run_load(2, 100, 0);

    fill_bytes(w2, 32'h88888889);
    run_load(2, 100, 0);

    bad_start(0);
    bad_start(257);

    w1 = new[1];
    w1[0] = 32'h12345678;
    fill_bytes(w1, 32'h12345678);
    run_load(1, -1, 0);

    fill_bytes(w2, 32'h88888888);
    reset_mid_load();
    run_load(2, 100, 0);

    run_load(2, 100, 1);

    w1[0] = 32'hAABBCCDD;
    fill_bytes(w1, 32'hAABBCCDD);
    run_load(1, 100, 0);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(6, 1);
      fill_random(n, ($urandom_range(1, 0) == 1));
      run_load(n, $urandom_range(100, 30), 0);
    end

    fill_random(1 << ADDR_W, 0);
    run_load(1 << ADDR_W, 100, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
